irq_controller: RTL

- Prioritised interrupt controller that drives the Beta CPU's irq and xadr (interrupt vector address) inputs.
- Collects up to NSRC single-cycle event pulses from peripherals (paddle sensors, ball tracker, frame timer) into pending bits, applies a mask, and selects the highest-priority source.
- Presents a vector, then runs a claim / end-of-interrupt (EOI) handshake with the handler software through a 4-word memory-mapped register window on the Beta data bus.

---
 rtl/irq_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
`default_nettype none
// =============================================================================
// irq_controller : prioritised interrupt controller with claim/EOI window
// Revision 1.0
// =============================================================================
module irq_controller #(
  parameter int          NSRC       = 8,
  parameter logic [30:0] VEC_BASE   = 31'h00000100,
  parameter int          VEC_STRIDE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            io_sel,
  input  logic            io_we,
  input  logic [1:0]      io_addr,
  input  logic [31:0]     io_wdata,
  output logic [31:0]     io_rdata,
  output logic            irq,
  output logic [30:0]     xadr
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  localparam logic [1:0] A_PENDING = 2'd0;
  localparam logic [1:0] A_MASK    = 2'd1;
  localparam logic [1:0] A_CLAIM   = 2'd2;
  localparam logic [1:0] A_EOI     = 2'd3;

  localparam logic [NSRC-1:0] SRC_ONE = NSRC'(1);

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] pending_next;
  logic [NSRC-1:0] pend_clr;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] edges;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] cur_sel;
  logic [4:0]      cur_id;
  logic [4:0]      win;
  logic            any;
  logic            rd;
  logic            wr;
  logic            live;
  logic            claim;
  logic            eoi;
  logic [31:0]     rdata_next;
  logic            unused_wdata;

  assign unused_wdata = &{1'b0, io_wdata[31:NSRC]};

  assign edges    = src & ~src_q;
  assign eligible = pending & mask;
  assign any      = |eligible;

  // Lowest index wins: scan from the top so the last hit is the smallest.
  always_comb begin
    win = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) win = 5'(i);
    end
  end

  assign rd      = io_sel & ~io_we;
  assign wr      = io_sel & io_we;
  assign cur_sel = SRC_ONE << cur_id;
  // The latched request is still backed by a pending, unmasked source.
  assign live    = (state == S_REQ) && (|(cur_sel & pending & mask));
  assign claim   = rd && (io_addr == A_CLAIM) && live;
  assign eoi     = wr && (io_addr == A_EOI);

  // New edges are OR-ed in last so a set always beats a same-cycle clear.
  always_comb begin
    pend_clr = '0;
    if (wr && (io_addr == A_PENDING)) pend_clr = io_wdata[NSRC-1:0];
    if (claim) pend_clr = pend_clr | cur_sel;
    pending_next = (pending & ~pend_clr) | edges;
  end

  always_comb begin
    rdata_next = '0;
    case (io_addr)
      A_PENDING: rdata_next = 32'(pending);
      A_MASK:    rdata_next = 32'(mask);
      A_CLAIM:   rdata_next = {live, 26'b0, cur_id};
      default:   rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (any) state_next = S_REQ;
      end
      S_REQ: begin
        if (claim)      state_next = S_SERVICE;
        else if (!live) state_next = S_IDLE;
      end
      S_SERVICE: begin
        if (eoi) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    irq = (state == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q    <= '0;
      pending  <= '0;
      mask     <= '0;
      cur_id   <= '0;
      xadr     <= VEC_BASE;
      io_rdata <= '0;
    end else begin
      src_q   <= src;
      pending <= pending_next;
      if (wr && (io_addr == A_MASK)) mask <= io_wdata[NSRC-1:0];
      if ((state == S_IDLE) && any) begin
        cur_id <= win;
        xadr   <= VEC_BASE + 31'(win) * 31'(VEC_STRIDE);
      end
      if (rd) io_rdata <= rdata_next;
    end
  end

endmodule
`default_nettype wire
